// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback (A) vs buffered long-latency results (B),
// with a pending-write scoreboard. Optional result forwarding is enabled by REGFILE_WB_FWD_EN.
module regfile_wb_arbiter #(
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4,
    parameter int DW         = 32
) (
    input  logic          Clk,
    input  logic          rst,
    input  logic          a_valid,
    input  logic [4:0]    a_rw,
    input  logic [DW-1:0] a_data,
    output logic          a_stall,
    input  logic          iss_valid,
    input  logic [4:0]    iss_rw,
    output logic          iss_ready,
    input  logic          b_valid,
    input  logic [4:0]    b_rw,
    input  logic [DW-1:0] b_data,
    output logic          b_ready,
    input  logic [4:0]    RX,
    input  logic [4:0]    RY,
    output logic          hazard_x,
    output logic          hazard_y,
`ifdef REGFILE_WB_FWD_EN
    input  logic [DW-1:0] busX_in,
    input  logic [DW-1:0] busY_in,
    output logic [DW-1:0] busX_fwd,
    output logic [DW-1:0] busY_fwd,
`endif
    output logic          WEN,
    output logic [4:0]    RW,
    output logic [DW-1:0] busW
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [AW:0]   DEPTH_C    = (AW + 1)'(FIFO_DEPTH);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [4:0]    fifo_rw_q   [FIFO_DEPTH];
    logic [DW-1:0] fifo_data_q [FIFO_DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic [31:0]   pend_q,   pend_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          wen_q,    wen_d;
    logic [4:0]    rw_q,     rw_d;
    logic [DW-1:0] busw_q,   busw_d;

    logic          fifo_nonempty;
    logic          fifo_full;
    logic          push;
    logic          grant_a;
    logic          grant_b;
    logic          issue;
    logic [4:0]    head_rw;
    logic [DW-1:0] head_data;

    assign fifo_nonempty = (count_q != '0);
    assign fifo_full     = (count_q == DEPTH_C);
    assign head_rw       = fifo_rw_q[rd_ptr_q];
    assign head_data     = fifo_data_q[rd_ptr_q];

    assign b_ready   = ~fifo_full;
    assign a_stall   = a_valid & fifo_nonempty & (starve_q == STARVE_LIM);
    assign iss_ready = ~pend_q[iss_rw] | (iss_rw == 5'd0);

    assign push    = b_valid & b_ready;
    assign issue   = iss_valid & iss_ready & (iss_rw != 5'd0);
    assign grant_a = a_valid & ~a_stall;
    assign grant_b = ~grant_a & fifo_nonempty;

`ifdef REGFILE_WB_FWD_EN
    assign hazard_x = (RX != 5'd0) & pend_q[RX];
    assign hazard_y = (RY != 5'd0) & pend_q[RY];
    assign busX_fwd = (wen_q && (rw_q == RX) && (RX != 5'd0)) ? busw_q : busX_in;
    assign busY_fwd = (wen_q && (rw_q == RY) && (RY != 5'd0)) ? busw_q : busY_in;
`else
    // Without forwarding, the register being written this cycle is not yet readable.
    assign hazard_x = (RX != 5'd0) & (pend_q[RX] | (wen_q & (rw_q == RX)));
    assign hazard_y = (RY != 5'd0) & (pend_q[RY] | (wen_q & (rw_q == RY)));
`endif

    assign WEN  = wen_q;
    assign RW   = rw_q;
    assign busW = busw_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        pend_d   = pend_q;
        starve_d = '0;
        wen_d    = 1'b0;
        rw_d     = rw_q;
        busw_d   = busw_q;

        if (grant_a) begin
            wen_d  = (a_rw != 5'd0);
            rw_d   = a_rw;
            busw_d = a_data;
            if (fifo_nonempty) begin
                starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + SW'(1);
            end
        end else if (grant_b) begin
            wen_d          = (head_rw != 5'd0);
            rw_d           = head_rw;
            busw_d         = head_data;
            rd_ptr_d       = rd_ptr_q + AW'(1);
            pend_d[head_rw] = 1'b0;
        end

        // A fresh issue wins over a same-cycle clear so a new owner is never lost.
        if (issue) begin
            pend_d[iss_rw] = 1'b1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, grant_b};
    end

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            pend_q   <= '0;
            starve_q <= '0;
            wen_q    <= 1'b0;
            rw_q     <= '0;
            busw_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
            starve_q <= starve_d;
            wen_q    <= wen_d;
            rw_q     <= rw_d;
            busw_q   <= busw_d;
        end
    end

    // Buffer storage carries no reset; occupancy alone decides which entries are live.
    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_rw_q[wr_ptr_q]   <= b_rw;
            fifo_data_q[wr_ptr_q] <= b_data;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// against a queue-based reference model. Honours REGFILE_WB_FWD_EN when defined.
module tb_regfile_wb_arbiter;

    localparam int FIFO_DEPTH = 2;
    localparam int STARVE_MAX = 4;
    localparam int DW         = 32;

    logic          Clk;
    logic          rst;
    logic          a_valid;
    logic [4:0]    a_rw;
    logic [DW-1:0] a_data;
    logic          a_stall;
    logic          iss_valid;
    logic [4:0]    iss_rw;
    logic          iss_ready;
    logic          b_valid;
    logic [4:0]    b_rw;
    logic [DW-1:0] b_data;
    logic          b_ready;
    logic [4:0]    RX;
    logic [4:0]    RY;
    logic          hazard_x;
    logic          hazard_y;
    logic          WEN;
    logic [4:0]    RW;
    logic [DW-1:0] busW;
`ifdef REGFILE_WB_FWD_EN
    logic [DW-1:0] busX_in;
    logic [DW-1:0] busY_in;
    logic [DW-1:0] busX_fwd;
    logic [DW-1:0] busY_fwd;
`endif

    regfile_wb_arbiter #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .STARVE_MAX(STARVE_MAX),
        .DW(DW)
    ) dut (
        .Clk(Clk),
        .rst(rst),
        .a_valid(a_valid),
        .a_rw(a_rw),
        .a_data(a_data),
        .a_stall(a_stall),
        .iss_valid(iss_valid),
        .iss_rw(iss_rw),
        .iss_ready(iss_ready),
        .b_valid(b_valid),
        .b_rw(b_rw),
        .b_data(b_data),
        .b_ready(b_ready),
        .RX(RX),
        .RY(RY),
        .hazard_x(hazard_x),
        .hazard_y(hazard_y),
`ifdef REGFILE_WB_FWD_EN
        .busX_in(busX_in),
        .busY_in(busY_in),
        .busX_fwd(busX_fwd),
        .busY_fwd(busY_fwd),
`endif
        .WEN(WEN),
        .RW(RW),
        .busW(busW)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [4:0]    rw;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          mq[$];
    logic [31:0]   m_pend;
    int            m_starve;
    logic          m_wen;
    logic [4:0]    m_rw;
    logic [DW-1:0] m_busw;

    int tests = 0;
    int fails = 0;
    int seen[3];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        mq.delete();
        m_pend   = '0;
        m_starve = 0;
        m_wen    = 1'b0;
        m_rw     = '0;
        m_busw   = '0;
    endtask

    function automatic logic m_hz(input logic [4:0] r);
`ifdef REGFILE_WB_FWD_EN
        return (r != 5'd0) && m_pend[r];
`else
        return (r != 5'd0) && (m_pend[r] || (m_wen && m_rw == r));
`endif
    endfunction

    function automatic bit in_queue(input logic [4:0] r);
        foreach (mq[i]) if (mq[i].rw == r) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: check combinational outputs, advance the model on the edge, check the write port.
    task automatic step();
        logic m_bready, m_astall, m_issready;
        ent_t e;
        #1;
        m_bready   = (mq.size() < FIFO_DEPTH);
        m_astall   = a_valid && (mq.size() > 0) && (m_starve == STARVE_MAX);
        m_issready = !m_pend[iss_rw] || (iss_rw == 5'd0);
        chk("b_ready", b_ready, m_bready);
        chk("a_stall", a_stall, m_astall);
        chk("iss_ready", iss_ready, m_issready);
        chk("hazard_x", hazard_x, m_hz(RX));
        chk("hazard_y", hazard_y, m_hz(RY));
        @(posedge Clk);
        if (a_valid && !m_astall) begin
            m_wen  = (a_rw != 5'd0);
            m_rw   = a_rw;
            m_busw = a_data;
            if (mq.size() > 0) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : m_starve;
            else               m_starve = 0;
        end else if (mq.size() > 0) begin
            e           = mq.pop_front();
            m_wen       = (e.rw != 5'd0);
            m_rw        = e.rw;
            m_busw      = e.data;
            m_pend[e.rw] = 1'b0;
            m_starve    = 0;
        end else begin
            m_wen    = 1'b0;
            m_starve = 0;
        end
        if (iss_valid && m_issready && iss_rw != 5'd0) m_pend[iss_rw] = 1'b1;
        if (b_valid && m_bready) mq.push_back(ent_t'{b_rw, b_data});
        #1;
        chk("WEN", WEN, m_wen);
        if (m_wen) begin
            chk("RW", RW, m_rw);
            chk("busW", busW, m_busw);
        end
        @(negedge Clk);
    endtask

    task automatic idle_inputs();
        a_valid = 0; a_rw = 0; a_data = 0;
        iss_valid = 0; iss_rw = 0;
        b_valid = 0; b_rw = 0; b_data = 0;
        RX = 0; RY = 0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
`ifdef REGFILE_WB_FWD_EN
        busX_in = 32'h0BAD_0BAD;
        busY_in = 32'h0C0C_0C0C;
`endif
        m_reset();
        repeat (2) @(negedge Clk);
        chk("rst_WEN", WEN, 1'b0);
        chk("rst_RW", RW, 5'd0);
        chk("rst_busW", busW, 32'd0);
        chk("rst_b_ready", b_ready, 1'b1);
        chk("rst_iss_ready", iss_ready, 1'b1);
        chk("rst_a_stall", a_stall, 1'b0);
        rst = 1'b0;

        // A-only writeback, including a dropped r0 write
        a_valid = 1; a_rw = 5'd5; a_data = 32'h1234;
        step();
        chk("a_only_WEN", WEN, 1'b1);
        chk("a_only_RW", RW, 5'd5);
        chk("a_only_busW", busW, 32'h1234);
        a_rw = 5'd0; a_data = 32'h5555;
        step();
        chk("a_r0_WEN", WEN, 1'b0);
        a_valid = 0;

        // Issue r7, result arrives with A idle
        iss_valid = 1; iss_rw = 5'd7;
        step();
        iss_valid = 0; RX = 5'd7;
        #1;
        chk("iss_hazard_x", hazard_x, 1'b1);
        b_valid = 1; b_rw = 5'd7; b_data = 32'hDEAD;
        step();
        b_valid = 0;
        step();
        chk("b_WEN", WEN, 1'b1);
        chk("b_RW", RW, 5'd7);
        chk("b_busW", busW, 32'hDEAD);
`ifdef REGFILE_WB_FWD_EN
        chk("pop_hazard_x", hazard_x, 1'b0);
        chk("fwd_busX", busX_fwd, 32'hDEAD);
`else
        chk("pop_hazard_x", hazard_x, 1'b1);
`endif
        step();
        chk("after_pop_hazard_x", hazard_x, 1'b0);

        // Starvation: one queued B entry against continuous A
        iss_valid = 1; iss_rw = 5'd9;
        step();
        iss_valid = 0;
        b_valid = 1; b_rw = 5'd9; b_data = 32'h9999;
        step();
        b_valid = 0;
        a_valid = 1; a_rw = 5'd2;
        for (int i = 0; i < 6; i++) begin
            a_data = 32'hA000 + i;
            #1;
            chk("starve_a_stall", a_stall, (i == 4));
            step();
            if (i == 4) begin
                chk("starve_RW", RW, 5'd9);
                chk("starve_busW", busW, 32'h9999);
            end
        end

        // Full FIFO under continuous A: three results, none lost or duplicated
        begin
            int pushed;
            bit accepted;
            pushed = 0;
            seen[0] = 0; seen[1] = 0; seen[2] = 0;
            for (int i = 0; i < 20; i++) begin
                a_data = 32'hB000 + i;
                if (pushed < 3) begin
                    b_valid = 1; b_rw = 5'(10 + pushed); b_data = 32'hC000 + pushed;
                end else begin
                    b_valid = 0;
                end
                accepted = b_valid && (mq.size() < FIFO_DEPTH);
                if (i == 2) begin
                    #1;
                    chk("full_b_ready", b_ready, 1'b0);
                end
                step();
                if (accepted) pushed++;
                if (WEN && RW >= 5'd10 && RW <= 5'd12) seen[RW - 10]++;
            end
            a_valid = 0; b_valid = 0;
            repeat (3) begin
                step();
                if (WEN && RW >= 5'd10 && RW <= 5'd12) seen[RW - 10]++;
            end
            chk("full_seen_r10", seen[0], 1);
            chk("full_seen_r11", seen[1], 1);
            chk("full_seen_r12", seen[2], 1);
        end

        // Second issue to a pending register is refused
        iss_valid = 1; iss_rw = 5'd3;
        step();
        #1;
        chk("reissue_iss_ready", iss_ready, 1'b0);
        step();
        iss_valid = 0;
        b_valid = 1; b_rw = 5'd3; b_data = 32'h3333;
        step();
        b_valid = 0;
        step();
        chk("r3_RW", RW, 5'd3);

        // Asynchronous reset in the middle of traffic
        iss_valid = 1; iss_rw = 5'd4;
        step();
        iss_valid = 0;
        a_valid = 1; a_rw = 5'd1;
        b_valid = 1; b_rw = 5'd4; b_data = 32'h4444;
        step();
        b_valid = 0;
        step();
        #2;
        rst = 1'b1;
        m_reset();
        #1;
        chk("mid_rst_WEN", WEN, 1'b0);
        chk("mid_rst_b_ready", b_ready, 1'b1);
        chk("mid_rst_a_stall", a_stall, 1'b0);
        iss_rw = 5'd4;
        #1;
        chk("mid_rst_iss_ready", iss_ready, 1'b1);
        for (int r = 0; r < 32; r++) begin
            RX = 5'(r);
            #0.1;
            chk("mid_rst_hazard_x", hazard_x, 1'b0);
        end
        @(negedge Clk);
        rst = 1'b0;
        idle_inputs();

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            a_valid   = ($urandom_range(0, 99) < 55);
            a_rw      = 5'($urandom_range(0, 31));
            a_data    = $urandom;
            iss_rw    = 5'($urandom_range(0, 31));
            iss_valid = ($urandom_range(0, 99) < 30) && !in_queue(iss_rw);
            b_valid   = ($urandom_range(0, 99) < 40);
            b_rw      = 5'($urandom_range(0, 31));
            b_data    = $urandom;
            RX        = 5'($urandom_range(0, 31));
            RY        = 5'($urandom_range(0, 31));
            step();
        end
        idle_inputs();
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
